// File: rtl/doc_safety_heartbeat_gen.sv
// doc_safety_heartbeat_gen: multi-channel toggling heartbeat with external-pulse or internal-divider source and sticky stall supervision
// Ports: clk, rst (sync, active-high); enable/mode/generateBit/clear_stall/inject [NUM_CH];
//        period [NUM_CH*CNT_W] (per-channel divider period), timeout [CNT_W] (0 = no supervision);
//        heartbeat/stalled [NUM_CH] registered outputs.
// Optional macro DOC_SAFETY_HB_FAULT_INJECT_EN: inject[i] blocks every heartbeat toggle on channel i.
module doc_safety_heartbeat_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       generateBit,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [CNT_W-1:0]        timeout,
  input  logic [NUM_CH-1:0]       clear_stall,
  input  logic [NUM_CH-1:0]       inject,
  output logic [NUM_CH-1:0]       heartbeat,
  output logic [NUM_CH-1:0]       stalled
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] STALL = 2'b10;
`ifndef DOC_SAFETY_HB_FAULT_INJECT_EN
  logic unused_inject;
  assign unused_inject = ^inject;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, per, lim;
    logic             hb_q, hb_d, mode_q, tgl, blk;
    assign per = period[i*CNT_W +: CNT_W];
    assign lim = (per == '0) ? '0 : per - 1'b1;
`ifdef DOC_SAFETY_HB_FAULT_INJECT_EN
    assign blk = inject[i];
`else
    assign blk = 1'b0;
`endif
    // One counter serves as gap counter (external) or divider (internal); the modes never share it at once.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgl     = 1'b0;
      if (state_q == IDLE) begin
        state_d = enable[i] ? RUN : IDLE;
        cnt_d   = '0;
      end else if (state_q == RUN) begin
        if (mode[i] != mode_q) begin
          cnt_d = '0;
        end else if (mode[i]) begin
          tgl   = cnt_q >= lim;
          cnt_d = tgl ? '0 : cnt_q + 1'b1;
        end else begin
          tgl   = generateBit[i];
          cnt_d = tgl ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
          // This cycle is the timeout-th pulseless one; a pulse here wins.
          if (!tgl && timeout != '0 && cnt_q >= timeout - 1'b1) state_d = STALL;
        end
        if (!enable[i]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end else if (clear_stall[i]) begin
        state_d = enable[i] ? RUN : IDLE;
        cnt_d   = '0;
      end
      hb_d = hb_q ^ (tgl & ~blk);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hb_q    <= 1'b0;
        mode_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hb_q    <= hb_d;
        mode_q  <= mode[i];
      end
    end
    assign heartbeat[i] = hb_q;
    assign stalled[i]   = state_q[1];
  end
endmodule

// File: tb/tb_doc_safety_heartbeat_gen.sv
// tb_doc_safety_heartbeat_gen: directed self-checking bench for doc_safety_heartbeat_gen
module tb_doc_safety_heartbeat_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  enable, mode, generateBit, clear_stall, inject, heartbeat, stalled;
  logic [63:0] period;
  logic [15:0] timeout;
  int          n_chk = 0;
  int          n_fail = 0;
`ifdef DOC_SAFETY_HB_FAULT_INJECT_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif
  doc_safety_heartbeat_gen #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .generateBit(generateBit),
    .period(period), .timeout(timeout), .clear_stall(clear_stall), .inject(inject),
    .heartbeat(heartbeat), .stalled(stalled)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; enable = '0; mode = '0; generateBit = '0; clear_stall = '0;
    inject = '0; period = '0; timeout = '0;
    step(2);
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_hb", heartbeat, 4'h0);
    check("rst_stalled", stalled, 4'h0);
    generateBit = 4'hF; step(1); generateBit = '0; step(1);
    check("idle_pulse_hb", heartbeat, 4'h0);
    // external toggling, consecutive pulses
    enable = 4'hF; step(1);
    generateBit = 4'b0001; step(1);
    check("ext_t1", heartbeat, 4'b0001);
    step(1);
    check("ext_t2", heartbeat, 4'b0000);
    generateBit = '0; step(8);
    check("ext_hold", heartbeat, 4'b0000);
    generateBit = 4'b0001; step(1); generateBit = '0;
    check("ext_t3", heartbeat, 4'b0001);
    check("ext_nostall", stalled, 4'h0);
    // internal divider: ch0 P=5, ch1 P=0 (toggle every cycle)
    do_reset();
    mode = 4'b0011; period[15:0] = 16'd5; period[31:16] = 16'd0; enable = 4'b0011;
    step(1);
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] e;
      step(1);
      e = '0;
      e[1] = (k % 2) == 1;
      e[0] = ((k / 5) % 2) == 1;
      check($sformatf("div_k%0d", k), heartbeat, e);
    end
    // stall detection with timeout 8
    do_reset();
    timeout = 16'd8; enable = 4'b0001;
    step(1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check($sformatf("stall_k%0d", k), stalled, (k >= 8) ? 4'b0001 : 4'b0000);
    end
    generateBit = 4'b0001; step(1); generateBit = '0;
    check("stall_frozen_hb", heartbeat, 4'h0);
    enable = '0; step(1);
    check("stall_ign_en", stalled, 4'b0001);
    enable = 4'b0001;
    clear_stall = 4'b0001; step(1); clear_stall = '0;
    check("clear_stalled", stalled, 4'h0);
    step(7);
    generateBit = 4'b0001; step(1); generateBit = '0;
    check("edge_pulse_nostall", stalled, 4'h0);
    check("edge_pulse_hb", heartbeat, 4'b0001);
    step(7);
    check("gap_restart_7", stalled, 4'h0);
    step(1);
    check("gap_restart_8", stalled, 4'b0001);
    enable = '0; clear_stall = 4'b0001; step(1); clear_stall = '0;
    check("clear_to_idle", stalled, 4'h0);
    generateBit = 4'b0001; step(1); generateBit = '0;
    check("idle_after_clear_hb", heartbeat, 4'b0001);
    // mode switch and enable drop
    do_reset();
    mode = 4'b0001; period[15:0] = 16'd5; enable = 4'b0001;
    step(1); step(4);
    mode = 4'b0000; step(1);
    check("mode_sw_notgl", heartbeat, 4'h0);
    mode = 4'b0001; step(1);
    step(4);
    check("mode_sw_restart4", heartbeat, 4'h0);
    step(1);
    check("mode_sw_restart5", heartbeat, 4'b0001);
    step(2);
    enable = '0; step(1);
    check("en_drop_hold", heartbeat, 4'b0001);
    step(3);
    check("en_drop_hold2", heartbeat, 4'b0001);
    enable = 4'b0001; step(1);
    step(4);
    check("reen_4", heartbeat, 4'b0001);
    step(1);
    check("reen_5", heartbeat, 4'b0000);
    // fault injection on ch1, period 4
    do_reset();
    mode = 4'b0010; period[31:16] = 16'd4; enable = 4'b0010; inject = 4'b0010;
    step(1); step(4);
    check("inj_4", heartbeat, FI ? 4'h0 : 4'b0010);
    check("inj_stalled", stalled, 4'h0);
    step(2); inject = '0; step(1);
    check("inj_rel_7", heartbeat, FI ? 4'h0 : 4'b0010);
    step(1);
    check("inj_rel_8", heartbeat, FI ? 4'b0010 : 4'h0);
    // reset overrides mid-count
    enable = 4'b0010; rst = 1'b1; step(1); rst = 1'b0;
    check("rst_mid_hb", heartbeat, 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/doc_safety_heartbeat_gen.md
# doc_safety_heartbeat_gen

Multi-channel heartbeat generator for the drive-on-chip safety subsystem. Each channel produces a toggling heartbeat that is safe to pass across clock domains to a downstream watchdog. A channel toggles either on an external single-cycle request pulse or from an internal programmable divider. In external mode, each channel also supervises its source and latches a sticky stall flag when request pulses stop arriving.

## Interface
Parameters:
- NUM_CH, 4, number of independent heartbeat channels (1..32)
- CNT_W, 16, width of period, timeout and internal counters

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- enable  in  NUM_CH  per-channel run enable
- mode  in  NUM_CH  per-channel mode: 0 = external pulse, 1 = internal divider
- generateBit  in  NUM_CH  per-channel single-cycle toggle request (external mode)
- period  in  NUM_CH*CNT_W  internal toggle period in cycles; channel i uses [i*CNT_W +: CNT_W]
- timeout  in  CNT_W  maximum run of pulseless cycles in external mode; 0 disables supervision
- clear_stall  in  NUM_CH  per-channel stall clear
- inject  in  NUM_CH  per-channel fault injection: suppresses toggles (effective only with macro)
- heartbeat  out  NUM_CH  per-channel heartbeat, registered
- stalled  out  NUM_CH  per-channel sticky stall flag, registered

## Operation
- Reset values: heartbeat = 0, stalled = 0, all FSMs in IDLE, all counters = 0.
- Each channel has its own FSM, with states IDLE, RUN and STALL.
- **IDLE → RUN:** when enable[i] = 1. Counters are zero on entry.
- **RUN → IDLE:** when enable[i] = 0. Counters are cleared; heartbeat holds its last value.
- **RUN → STALL:** in external mode with timeout ≠ 0, after `timeout` consecutive RUN cycles with generateBit[i] = 0.
- **STALL → RUN or IDLE:** only via clear_stall[i] = 1. Next state is RUN if enable[i] = 1, else IDLE; counters are cleared. While in STALL, enable[i] is ignored.
- stalled[i] = 1 exactly while the FSM is in STALL. Heartbeat is frozen in STALL.
- **External mode:**
  - A cycle in RUN with generateBit[i] = 1 toggles heartbeat[i] and zeroes the gap counter.
  - Otherwise the gap counter increments.
  - Consecutive pulses toggle on every pulse.
- **Internal mode:**
  - The divider counts 0..P-1, where P = period[i]; period = 0 is treated as P = 1.
  - When the divider reaches P-1, heartbeat toggles and the divider returns to 0.
  - generateBit is ignored and there is no supervision.
  - Period changes take effect at the next wrap.
- **Mode change while in RUN:** counters are cleared in that cycle and no toggle occurs.
- **Simultaneous events:**
  - A pulse on the cycle the gap would reach timeout wins: toggle, no stall.
  - clear_stall while not in STALL has no effect.
  - rst overrides everything, including mid-stall or mid-count.
- Counters saturate, never wrap. The gap counter saturates at 2^CNT_W − 1.

## Timing
- External: generateBit[i] high in cycle n → heartbeat[i] toggled from cycle n+1 (1-cycle latency).
- Internal: the first toggle is visible P cycles after the first RUN cycle, then every P cycles. The heartbeat period is 2P.
- Stall: with timeout = T, after T pulseless RUN cycles (cycles n..n+T-1), stalled[i] = 1 from cycle n+T.
- clear_stall in cycle n → stalled[i] = 0 from cycle n+1. Counting restarts from zero in cycle n+1.
- enable falling in cycle n → IDLE from cycle n+1. A pulse in cycle n is still honoured.

## Configuration
- Macro: DOC_SAFETY_HB_FAULT_INJECT_EN.
- **Defined:**
  - inject[i] = 1 blocks every heartbeat toggle on channel i.
  - Counters, gap supervision and the FSM run unchanged, so a downstream watchdog sees a frozen heartbeat while the generator itself reports no stall.
- **Undefined:**
  - The inject port is present but ignored; heartbeat behaviour is identical to inject = 0.
  - No inject-related logic is synthesised.

## Test plan
- **Reset values:** rst for 2 cycles, then release with enable = 0 → heartbeat = 0, stalled = 0. Pulses on generateBit cause no toggle.
- **External toggling:** NUM_CH = 4, mode = 0, enable = 1, timeout = 0; pulses on ch0 at cycles 10, 11, 20 → heartbeat[0] = 1, 0, 1 from cycles 11, 12, 21. Other channels stay 0.
- **Internal divider:** mode = 1, period = 5 → heartbeat toggles at cycles 5, 10, 15 after entering RUN. Period = 0 → toggles every cycle.
- **Stall detection:**
  - timeout = 8, no pulses from cycle 0 → stalled = 1 from cycle 8, heartbeat frozen.
  - A pulse at cycle 7 instead → no stall, toggle, gap restarts.
  - clear_stall → stalled = 0 next cycle.
- **Mode switch and enable drop:** switch mode mid-divider → no toggle that cycle, divider restarts. Drop enable → heartbeat holds its value; re-enable → count from zero.
- **Fault injection (macro defined):** inject[1] = 1 with internal period 4 → heartbeat[1] constant, stalled[1] = 0. Release inject → toggles resume at the next divider wrap.
